pixel_dispatcher: RTL and testbench

- Transmit side of the ray unit's pixel interface: scans a WIDTH x HEIGHT frame on `start`.
- Emits one normalised screen coordinate pair per issue with a single-cycle valid strobe; this drives the ray unit's `screen_x`/`screen_y`/`valid_in`.
- The ray unit has no ready signal, so flow control is credit-based. Each returned `valid_out` frees one credit.
- Signals frame completion once every issued ray has returned.

---
 rtl/pixel_dispatcher_pkg.sv | 22 ++
 rtl/pixel_coord_stepper.sv | 55 +++++
 rtl/pixel_dispatcher.sv | 123 ++++++++++++
 tb/tb_pixel_dispatcher.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_dispatcher_pkg.sv
// Shared types and default screen-space constants for the pixel dispatcher.
// Coordinates are Q16.16 signed fixed point.
package pixel_dispatcher_pkg;

  typedef logic signed [31:0] fp_t;

  localparam int FP_FRAC = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } disp_state_t;

  // 320x240 view: x spans [-1,1), y starts at 0.75 minus half a pixel
  localparam fp_t DEF_X0     = 32'hFFFF00CD;
  localparam fp_t DEF_STEP_X = 32'h0000019A;
  localparam fp_t DEF_Y0     = 32'h0000BF33;
  localparam fp_t DEF_STEP_Y = 32'h0000019A;

endpackage

// File: rtl/pixel_coord_stepper.sv
// Raster scan position plus incremental fixed-point screen coordinates.
// Advances one pixel per cycle when asked; load rewinds to the frame origin.
module pixel_coord_stepper
  import pixel_dispatcher_pkg::*;
#(
  parameter int  WIDTH  = 320,
  parameter int  HEIGHT = 240,
  parameter int  CW     = 9,
  parameter int  RW     = 8,
  parameter fp_t X0     = DEF_X0,
  parameter fp_t STEP_X = DEF_STEP_X,
  parameter fp_t Y0     = DEF_Y0,
  parameter fp_t STEP_Y = DEF_STEP_Y
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          advance,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output fp_t           next_x,
  output fp_t           next_y,
  output logic          last_pixel
);

  localparam logic [CW-1:0] LAST_COL = CW'(WIDTH - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(HEIGHT - 1);

  assign last_pixel = (col == LAST_COL) && (row == LAST_ROW);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col    <= '0;
      row    <= '0;
      next_x <= '0;
      next_y <= '0;
    end else if (load) begin
      col    <= '0;
      row    <= '0;
      next_x <= X0;
      next_y <= Y0;
    end else if (advance) begin
      if (col == LAST_COL) begin
        col    <= '0;
        row    <= (row == LAST_ROW) ? '0 : row + 1'b1;
        next_x <= X0;
        next_y <= next_y - STEP_Y;
      end else begin
        col    <= col + 1'b1;
        next_x <= next_x + STEP_X;
      end
    end
  end

endmodule

// File: rtl/pixel_dispatcher.sv
// Credit-limited frame scanner feeding the ray unit one pixel per cycle.
// Each returned result frees a credit; done pulses once all issued rays are back.
module pixel_dispatcher
  import pixel_dispatcher_pkg::*;
#(
  parameter int  WIDTH        = 320,
  parameter int  HEIGHT       = 240,
  parameter int  MAX_INFLIGHT = 64,
  parameter fp_t X0           = DEF_X0,
  parameter fp_t STEP_X       = DEF_STEP_X,
  parameter fp_t Y0           = DEF_Y0,
  parameter fp_t STEP_Y       = DEF_STEP_Y,
  localparam int CW = $clog2(WIDTH),
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1,
  localparam int IW = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          pix_valid,
  output logic [31:0]   screen_x,
  output logic [31:0]   screen_y,
  output logic [CW-1:0] pix_x,
  output logic [RW-1:0] pix_y,
  input  logic          result_valid,
  output logic          busy,
  output logic          done,
  output logic [IW-1:0] inflight,
  output logic          err_underflow
);

  localparam logic [IW-1:0] MAX_C = IW'(MAX_INFLIGHT);

  disp_state_t   state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  fp_t           next_x;
  fp_t           next_y;
  logic          last_pixel;
  logic          load;
  logic          issue;
  logic          underflow;
  logic [IW-1:0] inflight_base;
  logic [IW-1:0] inflight_next;

  // A return this cycle frees its credit in time for an issue on the same edge
  assign underflow     = result_valid && (inflight == '0);
  assign inflight_base = (result_valid && !underflow) ? inflight - 1'b1 : inflight;
  assign issue         = (state == ISSUE) && (inflight_base < MAX_C);
  assign inflight_next = issue ? inflight_base + 1'b1 : inflight_base;
  assign load          = (state == IDLE) && start;

  pixel_coord_stepper #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT),
    .CW    (CW),
    .RW    (RW),
    .X0    (X0),
    .STEP_X(STEP_X),
    .Y0    (Y0),
    .STEP_Y(STEP_Y)
  ) u_stepper (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .advance   (issue),
    .col       (col),
    .row       (row),
    .next_x    (next_x),
    .next_y    (next_y),
    .last_pixel(last_pixel)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      pix_valid     <= 1'b0;
      screen_x      <= '0;
      screen_y      <= '0;
      pix_x         <= '0;
      pix_y         <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      inflight      <= '0;
      err_underflow <= 1'b0;
    end else begin
      pix_valid <= 1'b0;
      done      <= 1'b0;
      inflight  <= inflight_next;
      case (state)
        IDLE: begin
          if (start) begin
            state <= ISSUE;
            busy  <= 1'b1;
          end
        end
        ISSUE: begin
          if (issue) begin
            pix_valid <= 1'b1;
            screen_x  <= next_x;
            screen_y  <= next_y;
            pix_x     <= col;
            pix_y     <= row;
            if (last_pixel) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (inflight_next == '0) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
      // A stray return on the start edge still counts as an error for the new frame
      if (underflow)  err_underflow <= 1'b1;
      else if (load)  err_underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pixel_dispatcher.sv
// Bench for pixel_dispatcher: two 4x2 instances (8 and 3 credits) checked every
// cycle against a pixel-count model, plus hand-computed literal expectations.
module tb_pixel_dispatcher;

  localparam int W = 4;
  localparam int H = 2;
  localparam logic [31:0] X0 = 32'hFFFF00CD;
  localparam logic [31:0] SX = 32'h0000019A;
  localparam logic [31:0] Y0 = 32'h0000BF33;
  localparam logic [31:0] SY = 32'h0000019A;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: frame progress as a count of issued pixels and outstanding rays
  typedef struct {
    int          mode;   // 0 idle, 1 frame active, 2 done cycle
    int          n;
    int          out;
    bit          err;
    bit          pv;
    bit          done;
    logic [31:0] sx;
    logic [31:0] sy;
    int          px;
    int          py;
  } mdl_t;

  function automatic mdl_t mreset();
    mdl_t r;
    r.mode = 0; r.n = 0; r.out = 0; r.err = 0; r.pv = 0; r.done = 0;
    r.sx = '0; r.sy = '0; r.px = 0; r.py = 0;
    return r;
  endfunction

  function automatic mdl_t step(mdl_t m, bit st, bit rt, int maxi);
    mdl_t r;
    int   base;
    bit   uf;
    r = m; r.pv = 0; r.done = 0;
    base = m.out; uf = 0;
    if (rt) begin
      if (m.out == 0) uf = 1;
      else base = m.out - 1;
    end
    r.out = base;
    case (m.mode)
      0: if (st) begin r.mode = 1; r.n = 0; r.err = 0; end
      1: begin
        if (m.n < W * H) begin
          if (base < maxi) begin
            r.pv  = 1;
            r.px  = m.n % W;
            r.py  = m.n / W;
            r.sx  = X0 + 32'(r.px) * SX;
            r.sy  = Y0 - 32'(r.py) * SY;
            r.n   = m.n + 1;
            r.out = base + 1;
          end
        end else if (base == 0) begin
          r.mode = 2;
          r.done = 1;
        end
      end
      default: r.mode = 0;
    endcase
    if (uf) r.err = 1;
    return r;
  endfunction

  // Instance A: 8 credits
  logic        a_rst, a_start, a_ret_man, a_auto, a_ret;
  logic [2:0]  a_pipe = '0;
  logic        a_pv, a_busy, a_done, a_err;
  logic [31:0] a_sx, a_sy;
  logic [1:0]  a_px;
  logic [0:0]  a_py;
  logic [3:0]  a_inf;
  assign a_ret = a_ret_man | (a_auto & a_pipe[2]);

  pixel_dispatcher #(.WIDTH(W), .HEIGHT(H), .MAX_INFLIGHT(8)) dut_a (
    .clk(clk), .rst(a_rst), .start(a_start), .pix_valid(a_pv),
    .screen_x(a_sx), .screen_y(a_sy), .pix_x(a_px), .pix_y(a_py),
    .result_valid(a_ret), .busy(a_busy), .done(a_done),
    .inflight(a_inf), .err_underflow(a_err));

  // Instance B: 3 credits
  logic        b_rst, b_start, b_ret_man, b_auto, b_ret;
  logic [2:0]  b_pipe = '0;
  logic        b_pv, b_busy, b_done, b_err;
  logic [31:0] b_sx, b_sy;
  logic [1:0]  b_px;
  logic [0:0]  b_py;
  logic [1:0]  b_inf;
  assign b_ret = b_ret_man | (b_auto & b_pipe[2]);

  pixel_dispatcher #(.WIDTH(W), .HEIGHT(H), .MAX_INFLIGHT(3)) dut_b (
    .clk(clk), .rst(b_rst), .start(b_start), .pix_valid(b_pv),
    .screen_x(b_sx), .screen_y(b_sy), .pix_x(b_px), .pix_y(b_py),
    .result_valid(b_ret), .busy(b_busy), .done(b_done),
    .inflight(b_inf), .err_underflow(b_err));

  mdl_t        ma, mb;
  int          a_pv_total = 0, a_done_total = 0, b_pv_total = 0, b_done_total = 0;
  logic [31:0] a_sx_log[64], a_sy_log[64], b_sx_log[64], b_sy_log[64];
  int          a_pv_cyc[64], a_done_cyc[8], b_px_log[64], b_py_log[64];

  always @(posedge clk) begin
    bit st, rt, rs;
    st = a_start; rt = a_ret; rs = a_rst;
    cyc++;
    if (rs) ma = mreset();
    else    ma = step(ma, st, rt, 8);
    #1;
    chk("a_pix_valid", 32'(a_pv), 32'(ma.pv));
    chk("a_busy", 32'(a_busy), 32'(ma.mode == 1));
    chk("a_done", 32'(a_done), 32'(ma.done));
    chk("a_inflight", 32'(a_inf), 32'(ma.out));
    chk("a_err", 32'(a_err), 32'(ma.err));
    chk("a_screen_x", a_sx, ma.sx);
    chk("a_screen_y", a_sy, ma.sy);
    chk("a_pix_x", 32'(a_px), 32'(ma.px));
    chk("a_pix_y", 32'(a_py), 32'(ma.py));
    if (a_pv) begin
      if (a_pv_total < 64) begin
        a_sx_log[a_pv_total] = a_sx;
        a_sy_log[a_pv_total] = a_sy;
        a_pv_cyc[a_pv_total] = cyc;
      end
      a_pv_total++;
    end
    if (a_done) begin
      if (a_done_total < 8) a_done_cyc[a_done_total] = cyc;
      a_done_total++;
    end
    a_pipe = {a_pipe[1:0], a_pv};
  end

  always @(posedge clk) begin
    bit st, rt, rs;
    st = b_start; rt = b_ret; rs = b_rst;
    if (rs) mb = mreset();
    else    mb = step(mb, st, rt, 3);
    #1;
    chk("b_pix_valid", 32'(b_pv), 32'(mb.pv));
    chk("b_busy", 32'(b_busy), 32'(mb.mode == 1));
    chk("b_done", 32'(b_done), 32'(mb.done));
    chk("b_inflight", 32'(b_inf), 32'(mb.out));
    chk("b_err", 32'(b_err), 32'(mb.err));
    chk("b_screen_x", b_sx, mb.sx);
    chk("b_screen_y", b_sy, mb.sy);
    chk("b_pix_x", 32'(b_px), 32'(mb.px));
    chk("b_pix_y", 32'(b_py), 32'(mb.py));
    if (b_pv) begin
      if (b_pv_total < 64) begin
        b_sx_log[b_pv_total] = b_sx;
        b_sy_log[b_pv_total] = b_sy;
        b_px_log[b_pv_total] = 32'(b_px);
        b_py_log[b_pv_total] = 32'(b_py);
      end
      b_pv_total++;
    end
    if (b_done) b_done_total++;
    b_pipe = {b_pipe[1:0], b_pv};
  end

  initial begin
    int d0;
    a_rst = 1; b_rst = 1; a_start = 0; b_start = 0;
    a_ret_man = 0; b_ret_man = 0; a_auto = 0; b_auto = 0;
    repeat (2) @(negedge clk);
    chk("rst_a_busy", 32'(a_busy), 0);
    chk("rst_a_screen_x", a_sx, 0);
    chk("rst_b_inflight", 32'(b_inf), 0);
    chk("rst_b_err", 32'(b_err), 0);
    a_rst = 0; b_rst = 0;
    @(negedge clk);

    // Basic frame on A with returns three edges after each issue
    a_auto = 1; a_start = 1;
    @(negedge clk); a_start = 0;
    for (int i = 0; i < 100 && a_done_total < 1; i++) @(negedge clk);
    chk("a_frame1_done_count", a_done_total, 1);
    chk("a_frame1_issues", a_pv_total, 8);
    chk("a_frame1_consecutive", a_pv_cyc[7] - a_pv_cyc[0], 7);
    chk("a_sx_pix1", a_sx_log[1], 32'hFFFF0267);
    chk("a_sx_pix3", a_sx_log[3], 32'hFFFF059B);
    chk("a_sx_pix4_reload", a_sx_log[4], 32'hFFFF00CD);
    chk("a_sy_row0", a_sy_log[0], 32'h0000BF33);
    chk("a_sy_row1", a_sy_log[4], 32'h0000BD99);
    chk("a_done_after_last_return", a_done_cyc[0] - a_pv_cyc[7], 3);

    // Credit stall on B: no returns
    b_start = 1;
    @(negedge clk); b_start = 0;
    repeat (8) @(negedge clk);
    chk("b_stall_issues", b_pv_total, 3);
    chk("b_stall_inflight", 32'(b_inf), 3);
    chk("b_stall_pv_low", 32'(b_pv), 0);
    b_ret_man = 1;
    @(negedge clk); b_ret_man = 0;
    chk("b_credit_issue", b_pv_total, 4);
    chk("b_credit_pv", 32'(b_pv), 1);
    chk("b_simul_inflight", 32'(b_inf), 3);
    repeat (4) @(negedge clk);
    chk("b_single_issue", b_pv_total, 4);
    b_ret_man = 1;
    @(negedge clk); b_ret_man = 0;
    chk("b_fifth_issue", b_pv_total, 5);

    // Asynchronous reset mid-frame
    #2 b_rst = 1;
    #1;
    chk("b_arst_busy", 32'(b_busy), 0);
    chk("b_arst_inflight", 32'(b_inf), 0);
    chk("b_arst_screen_x", b_sx, 0);
    chk("b_arst_screen_y", b_sy, 0);
    chk("b_arst_pix_y", 32'(b_py), 0);
    d0 = b_done_total;
    @(negedge clk); b_rst = 0;
    repeat (5) @(negedge clk);
    chk("b_no_done_after_rst", b_done_total, d0);

    b_auto = 1; b_start = 1;
    @(negedge clk); b_start = 0;
    for (int i = 0; i < 20 && b_pv_total < 6; i++) @(negedge clk);
    chk("b_restart_sx", b_sx_log[5], 32'hFFFF00CD);
    chk("b_restart_sy", b_sy_log[5], 32'h0000BF33);
    chk("b_restart_px", b_px_log[5], 0);
    chk("b_restart_py", b_py_log[5], 0);
    for (int i = 0; i < 200 && b_done_total < d0 + 1; i++) @(negedge clk);
    chk("b_restart_done", b_done_total, d0 + 1);

    // Stray return in IDLE
    b_auto = 0;
    repeat (3) @(negedge clk);
    b_ret_man = 1;
    @(negedge clk); b_ret_man = 0;
    chk("b_underflow_err", 32'(b_err), 1);
    chk("b_underflow_inflight", 32'(b_inf), 0);
    b_start = 1;
    @(negedge clk); b_start = 0;
    chk("b_start_clears_err", 32'(b_err), 0);
    chk("b_start_busy", 32'(b_busy), 1);
    b_auto = 1;
    for (int i = 0; i < 200 && b_done_total < d0 + 2; i++) @(negedge clk);
    chk("b_frame3_done", b_done_total, d0 + 2);

    // start held high on A: back-to-back frames
    a_start = 1;
    for (int i = 0; i < 100 && a_done_total < 2; i++) @(negedge clk);
    chk("a_frame2_done", a_done_total, 2);
    @(negedge clk);
    chk("a_gap_idle_busy", 32'(a_busy), 0);
    chk("a_gap_idle_pv", 32'(a_pv), 0);
    @(negedge clk);
    chk("a_gap_issue_busy", 32'(a_busy), 1);
    for (int i = 0; i < 20 && a_pv_total < 17; i++) @(negedge clk);
    chk("a_next_frame_gap", a_pv_cyc[16] - a_done_cyc[1], 3);
    a_start = 0;
    for (int i = 0; i < 100 && a_done_total < 3; i++) @(negedge clk);
    chk("a_frame3_done", a_done_total, 3);
    repeat (5) @(negedge clk);
    chk("a_total_issues", a_pv_total, 24);
    chk("a_final_idle", 32'(a_busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
